// File: rtl/s298_bist_ctrl.sv
// BIST sequencer for the s298 core: clears the CUT, drives LFSR patterns,
// compacts the six CUT outputs into a 16-bit MISR and flags a golden-signature match.
module s298_bist_ctrl #(
  parameter int          N_PATTERNS  = 255,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        ABORT,
  input  logic [5:0]  CUT_RESP,
  output logic        CUT_G0,
  output logic        CUT_G1,
  output logic        CUT_G2,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] SIGNATURE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [15:0] PCNT_LAST = 16'(N_PATTERNS - 1);
  localparam logic [3:0]  ICNT_LAST = 4'(INIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  lfsr, lfsr_nx;
  logic [15:0] misr, misr_nx;
  logic [15:0] pcnt, pcnt_nx;
  logic [3:0]  icnt, icnt_nx;
  logic        pass_q, pass_nx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {10'b0, r};
  endfunction

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state  <= S_IDLE;
      lfsr   <= 8'h01;
      misr   <= '0;
      pcnt   <= '0;
      icnt   <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_nx;
      lfsr   <= lfsr_nx;
      misr   <= misr_nx;
      pcnt   <= pcnt_nx;
      icnt   <= icnt_nx;
      pass_q <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    misr_nx  = misr;
    pcnt_nx  = pcnt;
    icnt_nx  = icnt;

    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nx = S_INIT;
          lfsr_nx  = 8'h01;
          misr_nx  = '0;
          pcnt_nx  = '0;
          icnt_nx  = '0;
        end
      end
      S_INIT: begin
        icnt_nx = icnt + 4'd1;
        if (icnt == ICNT_LAST) state_nx = S_TEST;
      end
      S_TEST: begin
        lfsr_nx = lfsr_step(lfsr);
        pcnt_nx = pcnt + 16'd1;
        // CUT responds one cycle late, so the first TEST cycle has nothing to capture
        if (pcnt != '0) misr_nx = misr_step(misr, CUT_RESP);
        if (pcnt == PCNT_LAST) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        misr_nx  = misr_step(misr, CUT_RESP);
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (ABORT) begin
      state_nx = S_IDLE;
      lfsr_nx  = lfsr;
      misr_nx  = misr;
      pcnt_nx  = pcnt;
      icnt_nx  = icnt;
    end

    // PASS is registered alongside the DONE state so it never glitches
    pass_nx = (state_nx == S_DONE) && (misr_nx == GOLDEN_SIG);
  end

  always_comb begin
    CUT_G0 = 1'b0;
    CUT_G1 = 1'b0;
    CUT_G2 = 1'b0;
    case (state)
      S_INIT: CUT_G0 = 1'b1;
      S_TEST: {CUT_G2, CUT_G1, CUT_G0} = lfsr[2:0];
      default: ;
    endcase
  end

  assign BUSY      = (state == S_INIT) || (state == S_TEST) || (state == S_FLUSH);
  assign DONE      = (state == S_DONE);
  assign PASS      = pass_q;
  assign SIGNATURE = misr;

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Self-checking bench for s298_bist_ctrl: random CUT responses folded by a
// queue-based signature model, plus single-pattern boundary instances.
module tb_s298_bist_ctrl;

  localparam int N = 255;
  localparam int I = 2;

  logic CK = 1'b0;
  logic RN = 1'b0;

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [5:0]  resp0  = '0;
  logic        a_g0, a_g1, a_g2, a_busy, a_done, a_pass;
  logic [15:0] a_sig;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [5:0]  resp1  = '0;
  logic        b_g0, b_g1, b_g2, b_busy, b_done, b_pass;
  logic [15:0] b_sig;
  logic        c_g0, c_g1, c_g2, c_busy, c_done, c_pass;
  logic [15:0] c_sig;

  s298_bist_ctrl u_dut (
    .CK(CK), .RN(RN), .START(start0), .ABORT(abort0), .CUT_RESP(resp0),
    .CUT_G0(a_g0), .CUT_G1(a_g1), .CUT_G2(a_g2),
    .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .SIGNATURE(a_sig)
  );

  s298_bist_ctrl #(.N_PATTERNS(1), .INIT_CYCLES(1), .GOLDEN_SIG(16'h0000)) u_one (
    .CK(CK), .RN(RN), .START(start1), .ABORT(abort1), .CUT_RESP(resp1),
    .CUT_G0(b_g0), .CUT_G1(b_g1), .CUT_G2(b_g2),
    .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .SIGNATURE(b_sig)
  );

  s298_bist_ctrl #(.N_PATTERNS(1), .INIT_CYCLES(1), .GOLDEN_SIG(16'h002A)) u_one_g (
    .CK(CK), .RN(RN), .START(start1), .ABORT(abort1), .CUT_RESP(resp1),
    .CUT_G0(c_g0), .CUT_G1(c_g1), .CUT_G2(c_g2),
    .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .SIGNATURE(c_sig)
  );

  always #5 CK = ~CK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {10'b0, r};
  endfunction

  logic [7:0] pat [N];
  logic [5:0] resp_mem [N + I + 2];
  logic [5:0] capt [$];

  function automatic logic [15:0] fold_capt();
    logic [15:0] m = '0;
    foreach (capt[i]) m = misr_next(m, capt[i]);
    return m;
  endfunction

  // mode 0: responses tied 0; 1: fresh random (recorded); 2: replay recorded
  task automatic run0(input int mode, input int pulse_p, input int abort_p,
                      output logic [15:0] sig);
    logic [4:0]  exp;
    logic [5:0]  r;
    capt.delete();
    sig    = '0;
    start0 = 1'b1;
    abort0 = 1'b0;
    for (int j = 0; j <= I + N + 1; j++) begin
      @(negedge CK);
      start0 = 1'b0;
      abort0 = 1'b0;
      if (j < I)            exp = 5'b10_001;
      else if (j < I + N)   exp = {2'b10, pat[j - I][2:0]};
      else if (j == I + N)  exp = 5'b10_000;
      else                  exp = 5'b01_000;
      chk("run_outputs", {27'b0, a_busy, a_done, a_g2, a_g1, a_g0}, {27'b0, exp});
      if (j < I + N + 1) chk("pass_low_while_running", {31'b0, a_pass}, 32'h0);
      if (j == I + N + 1) begin
        sig = fold_capt();
        chk("final_signature", {16'b0, a_sig}, {16'b0, sig});
        chk("final_pass", {31'b0, a_pass}, {31'b0, sig == 16'h0000});
      end else begin
        if (mode == 0)      r = '0;
        else if (mode == 1) begin r = 6'($urandom); resp_mem[j] = r; end
        else                r = resp_mem[j];
        resp0 = r;
        if (j >= I && (j - I) == abort_p) begin
          abort0 = 1'b1;
          start0 = 1'b1;
          @(negedge CK);
          abort0 = 1'b0;
          start0 = 1'b0;
          sig = fold_capt();
          chk("abort_idle", {26'b0, a_busy, a_done, a_pass, a_g2, a_g1, a_g0}, 32'h0);
          chk("abort_sig_kept", {16'b0, a_sig}, {16'b0, sig});
          repeat (5) begin
            @(negedge CK);
            chk("abort_no_done", {30'b0, a_busy, a_done}, 32'h0);
          end
          return;
        end
        if (j >= I && (j - I) == pulse_p) start0 = 1'b1;
        if (j > I && j <= I + N) capt.push_back(r);
      end
    end
  endtask

  logic [15:0] s0, s1, s2, sa, s3;
  logic [7:0]  l;

  initial begin
    l = 8'h01;
    for (int p = 0; p < N; p++) begin
      pat[p] = l;
      l = lfsr_next(l);
    end

    RN = 1'b0; start0 = 1'b1; start1 = 1'b1;
    repeat (3) begin
      @(negedge CK);
      chk("reset_a", {10'b0, a_busy, a_done, a_pass, a_g2, a_g1, a_g0, a_sig}, 32'h0);
      chk("reset_b", {10'b0, b_busy, b_done, b_pass, b_g2, b_g1, b_g0, b_sig}, 32'h0);
    end
    start0 = 1'b0; start1 = 1'b0; RN = 1'b1;
    repeat (2) begin
      @(negedge CK);
      chk("post_reset_idle", {10'b0, a_busy, a_done, a_pass, a_g2, a_g1, a_g0, a_sig}, 32'h0);
    end

    run0(0, -1, -1, s0);
    chk("zero_resp_sig", {16'b0, s0}, 32'h0);
    run0(1, 5, -1, s1);
    run0(2, -1, -1, s2);
    chk("restart_same_sig", {16'b0, s2}, {16'b0, s1});
    run0(1, -1, 10, sa);
    run0(1, -1, -1, s3);

    // ABORT beats START while in DONE
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge CK);
    start0 = 1'b0; abort0 = 1'b0;
    chk("abort_over_start", {29'b0, a_busy, a_done, a_pass}, 32'h0);
    chk("idle_holds_sig", {16'b0, a_sig}, {16'b0, s3});

    // asynchronous reset in the middle of a run
    start0 = 1'b1;
    @(negedge CK);
    start0 = 1'b0;
    repeat (20) @(negedge CK);
    #2 RN = 1'b0;
    #1 chk("async_reset", {10'b0, a_busy, a_done, a_pass, a_g2, a_g1, a_g0, a_sig}, 32'h0);
    @(negedge CK);
    RN = 1'b1;
    repeat (3) begin
      @(negedge CK);
      chk("after_async_reset", {30'b0, a_busy, a_done}, 32'h0);
    end

    // single-pattern instances: INIT, TEST, FLUSH, DONE
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    chk("one_init", {27'b0, b_busy, b_done, b_g2, b_g1, b_g0}, {27'b0, 5'b10_001});
    resp1 = 6'h2A;
    @(negedge CK);
    chk("one_test", {27'b0, b_busy, b_done, b_g2, b_g1, b_g0}, {27'b0, 5'b10_001});
    resp1 = 6'h15;
    @(negedge CK);
    chk("one_flush", {27'b0, b_busy, b_done, b_g2, b_g1, b_g0}, {27'b0, 5'b10_000});
    chk("one_flush_sig", {16'b0, b_sig}, 32'h0);
    resp1 = 6'h2A;
    @(negedge CK);
    resp1 = '0;
    chk("one_done", {30'b0, b_busy, b_done}, 32'h1);
    chk("one_sig", {16'b0, b_sig}, 32'h002A);
    chk("one_pass_gold0", {31'b0, b_pass}, 32'h0);
    chk("one_sig_g", {16'b0, c_sig}, 32'h002A);
    chk("one_pass_gold2a", {30'b0, c_done, c_pass}, 32'h3);
    @(negedge CK);
    chk("one_done_holds", {14'b0, c_done, c_pass, c_sig}, {14'b0, 2'b11, 16'h002A});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
